// File: rtl/mult_job_sequencer.sv
// Operand-pair FIFO feeding a start/done multiplier, with a single registered
// result slot on the output side. One job is in flight at a time.
module mult_job_sequencer #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_multiplier,
  input  logic [WIDTH-1:0]     in_multiplicand,
  output logic                 start,
  output logic [WIDTH-1:0]     multiplier,
  output logic [WIDTH-1:0]     multiplicand,
  input  logic [2*WIDTH-1:0]   product,
  input  logic                 productDone,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state, state_nxt;
  logic [2*WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, empty, push, pop, capture, drain;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == IDLE) && !empty;
  // A new result may land only when the slot is free or being emptied this cycle.
  assign capture  = (state == WAIT) && productDone && (!out_valid || out_ready);
  assign drain    = out_valid && out_ready;

  // NOTE: the storage array has no reset; validity is tracked solely by the
  // pointers and count, so clearing the data would only cost reset fanout.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_multiplier, in_multiplicand};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      multiplier   <= '0;
      multiplicand <= '0;
    end else if (pop) begin
      {multiplier, multiplicand} <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_product <= '0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_product <= product;
    end else if (drain) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = (state == ISSUE);
    busy  = (state == ISSUE) || (state == WAIT);
  end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a behavioural fixed-latency
// multiplier that can be stalled to hold jobs in WAIT.
module tb_mult_job_sequencer;
  localparam int WIDTH = 128;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    a, b;
  logic                start;
  logic [WIDTH-1:0]    multiplier, multiplicand;
  logic [2*WIDTH-1:0]  mprod;
  logic                mdone;
  logic                out_valid, out_ready;
  logic [2*WIDTH-1:0]  out_product;
  logic                busy;
  logic                stall;
  int                  mcnt;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int ov_cnt = 0;
  logic [2*WIDTH-1:0] results[$];

  always #5 clk = ~clk;

  mult_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_multiplier(a), .in_multiplicand(b), .start(start),
    .multiplier(multiplier), .multiplicand(multiplicand),
    .product(mprod), .productDone(mdone), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .busy(busy)
  );

  // Multiplier model: done drops on start and rises LAT unstalled cycles later.
  always @(posedge clk) begin
    if (rst) begin
      mdone <= 1'b0;
      mcnt  <= 0;
      mprod <= '0;
    end else if (start) begin
      mdone <= 1'b0;
      mcnt  <= LAT;
      mprod <= {{WIDTH{1'b0}}, multiplier} * {{WIDTH{1'b0}}, multiplicand};
    end else if (mcnt != 0 && !stall) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mdone <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (start) start_cnt++;
      if (out_valid) ov_cnt++;
      if (out_valid && out_ready) results.push_back(out_product);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    start_cnt = 0;
    ov_cnt = 0;
    results.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0;
    a = '0; b = '0;
    repeat (2) tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_product !== '0) begin errors++; $display("FAIL reset_out_product: got %h want 0", out_product); end
    checks++; if (multiplier !== '0 || multiplicand !== '0) begin errors++; $display("FAIL reset_operands: got %h/%h want 0/0", multiplier, multiplicand); end
    rst = 1'b0;
    tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single;
    clear_mon();
    out_ready = 1'b1;
    in_valid = 1'b1; a = WIDTH'(3); b = WIDTH'(5);
    tick;
    in_valid = 1'b0;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL single_no_early_start: got %b want 0", start); end
    tick;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", start); end
    checks++; if (multiplier !== WIDTH'(3) || multiplicand !== WIDTH'(5)) begin errors++; $display("FAIL single_operands: got %0d/%0d want 3/5", multiplier, multiplicand); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    for (int c = 0; c < 30 && results.size() == 0; c++) tick;
    repeat (3) tick;
    checks++; if (results.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", results.size()); end
    if (results.size() > 0) begin
      checks++; if (results[0] !== (2*WIDTH)'(15)) begin errors++; $display("FAIL single_product: got %0d want 15", results[0]); end
    end
    checks++; if (ov_cnt != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d want 1", ov_cnt); end
    checks++; if (start_cnt != 1) begin errors++; $display("FAIL single_start_pulses: got %0d want 1", start_cnt); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_after: got busy=%b out_valid=%b want 0/0", busy, out_valid); end
  endtask

  task automatic test_fill;
    logic [2*WIDTH-1:0] exp_p;
    clear_mon();
    out_ready = 1'b1; stall = 1'b1;
    for (int k = 0; k <= DEPTH; k++) begin
      in_valid = 1'b1; a = WIDTH'(k + 1); b = WIDTH'(k + 2);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", k, in_ready); end
      tick;
    end
    a = WIDTH'(100); b = WIDTH'(100);
    for (int k = 0; k < 3; k++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_%0d: got %b want 0", k, in_ready); end
      tick;
    end
    in_valid = 1'b0;
    stall = 1'b0;
    for (int c = 0; c < 200 && results.size() < DEPTH + 1; c++) tick;
    repeat (10) tick;
    checks++; if (results.size() != DEPTH + 1) begin errors++; $display("FAIL fill_count: got %0d want %0d", results.size(), DEPTH + 1); end
    for (int k = 0; k < results.size() && k <= DEPTH; k++) begin
      exp_p = (2*WIDTH)'((k + 1) * (k + 2));
      checks++; if (results[k] !== exp_p) begin errors++; $display("FAIL fill_product_%0d: got %0d want %0d", k, results[k], exp_p); end
    end
    checks++; if (start_cnt != DEPTH + 1) begin errors++; $display("FAIL fill_starts: got %0d want %0d", start_cnt, DEPTH + 1); end
  endtask

  task automatic test_back_to_back;
    clear_mon();
    out_ready = 1'b0; stall = 1'b0;
    in_valid = 1'b1; a = WIDTH'(7);  b = WIDTH'(9);  tick;
    a = WIDTH'(11); b = WIDTH'(13); tick;
    in_valid = 1'b0;
    for (int c = 0; c < 50 && !out_valid; c++) tick;
    repeat (15) tick;
    checks++; if (out_valid !== 1'b1 || out_product !== (2*WIDTH)'(63)) begin errors++; $display("FAIL bp_hold: got valid=%b prod=%0d want 1/63", out_valid, out_product); end
    checks++; if (busy !== 1'b1 || mdone !== 1'b1) begin errors++; $display("FAIL bp_wait: got busy=%b done=%b want 1/1", busy, mdone); end
    checks++; if (start_cnt != 2 || results.size() != 0) begin errors++; $display("FAIL bp_no_capture: got starts=%0d results=%0d want 2/0", start_cnt, results.size()); end
    out_ready = 1'b1;
    for (int c = 0; c < 50 && results.size() < 2; c++) tick;
    repeat (3) tick;
    checks++; if (results.size() != 2) begin errors++; $display("FAIL bp_count: got %0d want 2", results.size()); end
    if (results.size() == 2) begin
      checks++; if (results[0] !== (2*WIDTH)'(63) || results[1] !== (2*WIDTH)'(143)) begin errors++; $display("FAIL bp_order: got %0d,%0d want 63,143", results[0], results[1]); end
    end
  endtask

  task automatic test_wrap;
    int sent;
    bit acc;
    logic [2*WIDTH-1:0] exp_p;
    clear_mon();
    sent = 0;
    for (int c = 0; c < 2000 && sent < 3 * DEPTH; c++) begin
      in_valid = 1'b1; a = WIDTH'(sent); b = WIDTH'(sent + 1);
      acc = in_ready;
      out_ready = 1'($urandom_range(0, 1));
      tick;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 2000 && results.size() < 3 * DEPTH; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick;
    end
    out_ready = 1'b1;
    repeat (10) tick;
    checks++; if (results.size() != 3 * DEPTH) begin errors++; $display("FAIL wrap_count: got %0d want %0d", results.size(), 3 * DEPTH); end
    for (int i = 0; i < results.size() && i < 3 * DEPTH; i++) begin
      exp_p = (2*WIDTH)'(i * (i + 1));
      checks++; if (results[i] !== exp_p) begin errors++; $display("FAIL wrap_product_%0d: got %0d want %0d", i, results[i], exp_p); end
    end
  endtask

  task automatic test_reset_in_wait;
    out_ready = 1'b1; stall = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = WIDTH'(k + 20); b = WIDTH'(2); tick;
    end
    in_valid = 1'b0;
    repeat (3) tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy_before: got %b want 1", busy); end
    rst = 1'b1; tick; rst = 1'b0;
    clear_mon();
    stall = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rw_after_reset: got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    repeat (20) tick;
    checks++; if (start_cnt != 0 || results.size() != 0) begin errors++; $display("FAIL rw_no_activity: got starts=%0d results=%0d want 0/0", start_cnt, results.size()); end
  endtask

  task automatic test_extremes;
    logic [2*WIDTH-1:0] e1;
    e1 = '1;
    e1 = e1 << (WIDTH + 1);
    e1[0] = 1'b1;
    clear_mon();
    out_ready = 1'b1; stall = 1'b0;
    in_valid = 1'b1; a = '1; b = '1; tick;
    a = '0; b = WIDTH'(12345); tick;
    in_valid = 1'b0;
    for (int c = 0; c < 50 && results.size() < 2; c++) tick;
    checks++; if (results.size() != 2) begin errors++; $display("FAIL ext_count: got %0d want 2", results.size()); end
    if (results.size() == 2) begin
      checks++; if (results[0] !== e1) begin errors++; $display("FAIL ext_max: got %h want %h", results[0], e1); end
      checks++; if (results[1] !== '0) begin errors++; $display("FAIL ext_zero: got %h want 0", results[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_reset_in_wait();
    test_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
